lane_tile_renderer: RTL
=======================

Name: lane_tile_renderer

Overview:
- Parametrised successor to the fixed-size piano-tile display path.
- Accepts one "draw/erase tile" request at a time and rasterises it into the VGA adapter port (VGA_X, VGA_Y, VGA_COLOR, plot), one pixel per clock.
- Supports N lanes, configurable tile geometry and colour depth, and vertical clipping for tiles partly above or below the screen.
- Sits between the game-logic FSM and the VGA adapter.

Parameters:
- X_W, 8: VGA_X width.
- Y_W, 7: VGA_Y width.
- COLOR_W, 3: colour width.
- LANES, 4: number of lanes.
- LANE_W, 40: lane width in pixels. LANES*LANE_W must be ≤ 2^X_W.
- TILE_GAP, 1: blank columns on each side of a tile inside its lane.
- TILE_H, 20: tile height in rows.
- SCREEN_H, 120: visible rows.
- BG_COLOR, 3'b000: colour used for erase.

Ports:
- CLOCK_50 in 1: system clock.
- resetn in 1: asynchronous active-low reset.
- req_valid in 1: request present.
- req_ready out 1: block idle; request accepted when req_valid && req_ready.
- req_lane in $clog2(LANES): target lane.
- req_y in Y_W+1: signed top row of the tile (may be negative).
- req_color in COLOR_W: tile colour.
- req_erase in 1: 1 = draw in BG_COLOR and ignore req_color.
- VGA_X out X_W: pixel x.
- VGA_Y out Y_W: pixel y.
- VGA_COLOR out COLOR_W: pixel colour.
- plot out 1: pixel write strobe.
- done out 1: one-cycle pulse when a request finishes.

Behaviour:
- Reset values:
  - req_ready=1; plot=0; done=0.
  - VGA_X=0; VGA_Y=0; VGA_COLOR=0.
  - FSM in IDLE.
- FSM states: IDLE, SETUP, DRAW, FINISH.
- IDLE:
  - req_ready=1.
  - On accept, latch all request fields; go to SETUP.
- SETUP (1 cycle, no plot):
  - x0 = lane*LANE_W + TILE_GAP.
  - x1 = x0 + LANE_W - 2*TILE_GAP - 1.
  - y0 = max(req_y, 0).
  - y1 = min(req_y + TILE_H - 1, SCREEN_H - 1). Computed at Y_W+2 bits signed, no wrap.
  - If y0 > y1, or lane ≥ LANES, go to FINISH with zero pixels plotted. Otherwise go to DRAW with counters at (x0, y0).
- DRAW:
  - Each cycle: plot=1 with registered VGA_X/VGA_Y/VGA_COLOR.
  - Raster order: x increments first; at x1, x returns to x0 and y increments.
  - After the pixel (x1, y1) go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Timing:
  - Accept at edge t.
  - First plot is high during cycle t+2.
  - Pixel count P = (x1-x0+1)*(y1-y0+1).
  - done is high in cycle t+2+P.
  - req_ready returns high in the cycle after done.
- req_ready=0 in SETUP/DRAW/FINISH. req_valid asserted during those states is ignored and not queued; the requester holds it.
- plot=0 in every non-DRAW cycle. VGA_X/Y/COLOR hold their last value when plot=0.
- Pixel outputs are registered; no combinational path from req_* to VGA outputs.
- Reset asserted mid-DRAW: immediate return to reset values and no done pulse. The partially drawn tile stays in the framebuffer; cleaning it up is the caller's responsibility.
- Back-to-back: a request held valid is accepted in the cycle after done+1.

Optional Feature:
- Macro: TILE_BORDER_EN.
- Defined:
  - Pixels with x==x0, x==x1, y==req_y, or y==req_y+TILE_H-1 are drawn in BG_COLOR when drawing (not erasing). This gives a 1-pixel outline.
  - Clipped edges are not drawn.
  - Pixel count and timing are unchanged.
- Undefined: every pixel uses req_color, or BG_COLOR on erase.

Decomposition:
- Package tile_pkg holds:
  - The FSM state enum (IDLE, SETUP, DRAW, FINISH).
  - Default geometry constants (LANE_W, TILE_H, SCREEN_H, TILE_GAP).
  - The BG_COLOR default.
- One natural sub-module: rect_scanner. It takes x0/x1/y0/y1 plus start and produces the x/y counters, a valid strobe and a last flag. It is reusable for full-screen clear.

Test Plan:
- Reset, then lane=0, y=10, color=3'b101, draw:
  - 38 x 20 = 760 plots.
  - x 1..38, y 10..29 in raster order, all colour 101.
  - done exactly 762 cycles after accept.
- lane=3, y=-5, erase:
  - y clipped to 0..14; x 121..158; 570 plots, all colour 000.
  - No plot with y ≥ 120 or x outside the range.
- lane=1, y=110: rows 110..119 only, 380 plots. Also y=-20 → 0 plots, done 2 cycles after accept.
- req_valid held through a whole draw with a second request:
  - Second request is accepted only in the cycle after done+1.
  - Its fields are unaffected by input changes during the first draw.
- resetn pulsed low at pixel 100 of a draw:
  - plot drops asynchronously; no done pulse; req_ready=1 after reset.
  - Next request draws correctly.
- With TILE_BORDER_EN, lane=2, y=40, colour 3'b010:
  - Perimeter pixels are 000, interior pixels are 010.
  - Count is still 760.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared state encodings and default tile geometry for the lane tile renderer.
package tile_pkg;

    typedef logic [1:0] tile_state_t;

    localparam tile_state_t ST_IDLE   = 2'd0;
    localparam tile_state_t ST_SETUP  = 2'd1;
    localparam tile_state_t ST_DRAW   = 2'd2;
    localparam tile_state_t ST_FINISH = 2'd3;

    localparam int DEF_LANE_W   = 40;
    localparam int DEF_TILE_GAP = 1;
    localparam int DEF_TILE_H   = 20;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_BG_COLOR = 0;

endpackage

// File: rtl/rect_scanner.sv
// Walks an inclusive rectangle in raster order, one coordinate per clock.
// Bounds must stay stable from start until last; also usable for a full-screen clear.
module rect_scanner #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           valid,
    output logic           last
);

    assign last = valid && (x == x1) && (y == y1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x     <= '0;
            y     <= '0;
            valid <= 1'b0;
        end else if (start) begin
            x     <= x0;
            y     <= y0;
            valid <= 1'b1;
        end else if (valid) begin
            if (last) begin
                valid <= 1'b0;
            end else if (x == x1) begin
                x <= x0;
                y <= y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/lane_tile_renderer.sv
// Rasterises one lane tile (draw or erase) into the VGA adapter, one pixel per clock.
// Define TILE_BORDER_EN to outline drawn tiles with a 1-pixel BG_COLOR border.
//
// state  | meaning
// IDLE   | ready for a request
// SETUP  | compute clipped rectangle, start scanner or skip when empty
// DRAW   | scanner emitting pixels
// FINISH | last pixel issued; done pulses next cycle
module lane_tile_renderer
    import tile_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter int LANES    = 4,
    parameter int LANE_W   = DEF_LANE_W,
    parameter int TILE_GAP = DEF_TILE_GAP,
    parameter int TILE_H   = DEF_TILE_H,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(DEF_BG_COLOR),
    localparam int LANE_SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [LANE_SEL_W-1:0] req_lane,
    input  logic [Y_W:0]          req_y,
    input  logic [COLOR_W-1:0]    req_color,
    input  logic                  req_erase,
    output logic [X_W-1:0]        VGA_X,
    output logic [Y_W-1:0]        VGA_Y,
    output logic [COLOR_W-1:0]    VGA_COLOR,
    output logic                  plot,
    output logic                  done
);

    localparam int YE_W = Y_W + 2;
    localparam logic signed [YE_W-1:0] SCREEN_LAST = YE_W'(SCREEN_H - 1);
    localparam logic signed [YE_W-1:0] TILE_SPAN   = YE_W'(TILE_H - 1);

    tile_state_t           state;
    logic [LANE_SEL_W-1:0] lane_q;
    logic [Y_W:0]          y_q;
    logic [COLOR_W-1:0]    color_q;
    logic                  erase_q;

    logic [X_W-1:0]         x_lo, x_hi;
    logic signed [YE_W-1:0] y_top, y_bot, y_lo, y_hi;
    logic                   lane_bad, empty, scan_start;
    logic [X_W-1:0]         scan_x;
    logic [Y_W-1:0]         scan_y;
    logic                   scan_valid, scan_last;
    logic [COLOR_W-1:0]     pix_color;

    // Geometry is derived from the latched request only, never from live inputs.
    assign x_lo     = X_W'(int'(lane_q) * LANE_W + TILE_GAP);
    assign x_hi     = x_lo + X_W'(LANE_W - 2 * TILE_GAP - 1);
    assign y_top    = $signed({y_q[Y_W], y_q});
    assign y_bot    = y_top + TILE_SPAN;
    assign y_lo     = y_top[YE_W-1] ? '0 : y_top;
    assign y_hi     = (y_bot > SCREEN_LAST) ? SCREEN_LAST : y_bot;
    assign lane_bad = int'(lane_q) >= LANES;
    assign empty    = lane_bad || (y_lo > y_hi);

    assign scan_start = (state == ST_SETUP) && !empty;
    assign req_ready  = (state == ST_IDLE) && !done;

    rect_scanner #(
        .X_W(X_W),
        .Y_W(Y_W)
    ) u_scanner (
        .clk   (CLOCK_50),
        .resetn(resetn),
        .start (scan_start),
        .x0    (x_lo),
        .x1    (x_hi),
        .y0    (Y_W'(y_lo)),
        .y1    (Y_W'(y_hi)),
        .x     (scan_x),
        .y     (scan_y),
        .valid (scan_valid),
        .last  (scan_last)
    );

    always_comb begin
        pix_color = erase_q ? BG_COLOR : color_q;
`ifdef TILE_BORDER_EN
        // Outline uses the unclipped rows, so clipped edges get no border.
        if (!erase_q && ((scan_x == x_lo) || (scan_x == x_hi) ||
                         ($signed({2'b00, scan_y}) == y_top) ||
                         ($signed({2'b00, scan_y}) == y_bot))) begin
            pix_color = BG_COLOR;
        end
`endif
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            lane_q    <= '0;
            y_q       <= '0;
            color_q   <= '0;
            erase_q   <= 1'b0;
            done      <= 1'b0;
            plot      <= 1'b0;
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
        end else begin
            done <= (state == ST_FINISH);
            plot <= scan_valid;
            if (scan_valid) begin
                VGA_X     <= scan_x;
                VGA_Y     <= scan_y;
                VGA_COLOR <= pix_color;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        lane_q  <= req_lane;
                        y_q     <= req_y;
                        color_q <= req_color;
                        erase_q <= req_erase;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP:  state <= empty ? ST_FINISH : ST_DRAW;
                ST_DRAW:   if (scan_last) state <= ST_FINISH;
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule
